booth_mul_arbiter: RTL and testbench

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

---
 rtl/booth_pkg.sv | 7 +
 rtl/booth_mul_arbiter_if.sv | 15 +
 rtl/booth_step.sv | 19 +
 rtl/booth_mul_arbiter.sv | 72 +++++++
 tb/tb_booth_mul_arbiter.sv | 137 +++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared width default, FSM encoding and requester ids
package booth_pkg;
  localparam int W_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;
endpackage

// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: two requester operand ports plus result handshake
interface booth_mul_arbiter_if import booth_pkg::*; #(parameter int W = W_DEF);
  logic a_valid, b_valid, a_ready, b_ready;
  logic [W-1:0] a_x, a_y, b_x, b_y;
  logic res_valid, res_ready, res_id, busy;
  logic [2*W-1:0] res_z;
  modport master (
    output a_valid, b_valid, a_x, a_y, b_x, b_y, res_ready,
    input a_ready, b_ready, res_valid, res_id, res_z, busy
  );
  modport slave (
    input a_valid, b_valid, a_x, a_y, b_x, b_y, res_ready,
    output a_ready, b_ready, res_valid, res_id, res_z, busy
  );
endinterface

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/sub/none followed by arithmetic shift of {acc, x}
module booth_step #(parameter int W = 4) (
  input  logic [W:0]   i_acc,
  input  logic [W-1:0] i_x,
  input  logic         i_xm1,
  input  logic [W-1:0] i_y,
  output logic [W:0]   o_acc,
  output logic [W-1:0] o_x,
  output logic         o_xm1
);
  logic [W:0] w_ys, w_sum;
  // acc is one bit wider than y so negating the most negative y cannot overflow
  assign w_ys  = {i_y[W-1], i_y};
  assign w_sum = ({i_x[0], i_xm1} == 2'b10) ? i_acc - w_ys :
                 ({i_x[0], i_xm1} == 2'b01) ? i_acc + w_ys : i_acc;
  assign o_acc = {w_sum[W], w_sum[W:1]};
  assign o_x   = {w_sum[0], i_x[W-1:1]};
  assign o_xm1 = i_x[0];
endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin shared sequential Booth multiplier for two requesters
module booth_mul_arbiter import booth_pkg::*; #(parameter int W = W_DEF) (
  input logic clk,
  input logic rst,
  booth_mul_arbiter_if.slave bus
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  state_t r_state;
  logic [W:0] r_acc, w_acc_n;
  logic [W-1:0] r_x, r_y, w_x_n;
  logic r_xm1, w_xm1_n, r_id, r_ptr, r_res_valid;
  logic [CW-1:0] r_cnt;
  logic [2*W-1:0] r_z;
  logic w_idle, w_grant_b, w_accept;
  assign w_idle    = r_state == IDLE;
  // r_ptr high means B holds priority on a tie
  assign w_grant_b = bus.b_valid & (~bus.a_valid | r_ptr);
  assign w_accept  = w_idle & (bus.a_valid | bus.b_valid);
  assign bus.a_ready   = w_idle & ~w_grant_b;
  assign bus.b_ready   = w_idle & w_grant_b;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_id;
  assign bus.res_z     = r_z;
  assign bus.busy      = ~w_idle;
  booth_step #(.W(W)) u_step (
    .i_acc(r_acc), .i_x(r_x), .i_xm1(r_xm1), .i_y(r_y),
    .o_acc(w_acc_n), .o_x(w_x_n), .o_xm1(w_xm1_n)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_res_valid <= 1'b0;
      r_z         <= '0;
      r_id        <= ID_A;
      r_ptr       <= ID_A;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_xm1       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= RUN;
          r_id    <= w_grant_b ? ID_B : ID_A;
          r_ptr   <= w_grant_b ? ID_A : ID_B;
          r_x     <= w_grant_b ? bus.b_x : bus.a_x;
          r_y     <= w_grant_b ? bus.b_y : bus.a_y;
          r_acc   <= '0;
          r_xm1   <= 1'b0;
          r_cnt   <= '0;
        end
        RUN: begin
          r_acc <= w_acc_n;
          r_x   <= w_x_n;
          r_xm1 <= w_xm1_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
            r_z         <= {w_acc_n[W-1:0], w_x_n};
          end
        end
        DONE: if (bus.res_ready) begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: directed checks of arbitration, timing, reset and a full W=4 sweep
module tb_booth_mul_arbiter;
  import booth_pkg::*;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  booth_mul_arbiter_if #(.W(W)) bus();
  booth_mul_arbiter #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("hs_res_valid", bus.res_valid, 0);
    chk("hs_busy", bus.busy, 0);
  endtask

  task automatic run(input logic id, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [2*W-1:0] ez, input string tag);
    int n;
    if (id == ID_B) begin bus.b_x = x; bus.b_y = y; bus.b_valid = 1'b1; end
    else begin bus.a_x = x; bus.a_y = y; bus.a_valid = 1'b1; end
    #1;
    chk({tag, "_ready"}, id ? bus.b_ready : bus.a_ready, 1);
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_x = ~x; bus.a_y = ~y; bus.b_x = ~x; bus.b_y = ~y;
    chk({tag, "_busy"}, bus.busy, 1);
    wait_done(n);
    chk({tag, "_lat"}, n, W);
    chk({tag, "_z"}, bus.res_z, ez);
    chk({tag, "_id"}, bus.res_id, id);
    handshake();
  endtask

  initial begin
    int n;
    logic [2*W-1:0] ez;
    bus.a_valid = 0; bus.b_valid = 0; bus.res_ready = 0;
    bus.a_x = 0; bus.a_y = 0; bus.b_x = 0; bus.b_y = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_z", bus.res_z, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_a_ready", bus.a_ready, 1);
    chk("rst_b_ready", bus.b_ready, 0);
    @(negedge clk);
    run(ID_A, 4'd3, 4'hE, 8'hFA, "a_3x-2");
    run(ID_B, 4'h8, 4'h8, 8'h40, "b_-8x-8");
    run(ID_B, 4'h8, 4'h7, 8'hC8, "b_-8x7");

    rst = 1'b1;
    bus.a_valid = 1; bus.b_valid = 1;
    bus.a_x = 4'd5; bus.a_y = 4'hD; bus.b_x = 4'h9; bus.b_y = 4'd6;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ez = (k % 2) ? 8'hD6 : 8'hF1;
      #1;
      chk("rr_a_ready", bus.a_ready, (k % 2) == 0);
      chk("rr_b_ready", bus.b_ready, (k % 2) == 1);
      @(negedge clk);
      wait_done(n);
      chk("rr_lat", n, W);
      chk("rr_id", bus.res_id, k % 2);
      chk("rr_z", bus.res_z, ez);
      if (k == 1) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_valid", bus.res_valid, 1);
          chk("stall_z", bus.res_z, ez);
          chk("stall_id", bus.res_id, 1);
          chk("stall_a_ready", bus.a_ready, 0);
          chk("stall_b_ready", bus.b_ready, 0);
          chk("stall_busy", bus.busy, 1);
        end
      end
      handshake();
    end
    bus.a_valid = 0; bus.b_valid = 0;

    bus.a_x = 4'd2; bus.a_y = 4'd3; bus.a_valid = 1;
    @(negedge clk);
    bus.a_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    bus.a_valid = 1; bus.b_valid = 1;
    #1;
    chk("mid_rst_ptr_a", bus.a_ready, 1);
    chk("mid_rst_ptr_b", bus.b_ready, 0);
    bus.b_valid = 0;
    run(ID_A, 4'hC, 4'd5, 8'hEC, "post_rst");

    for (int xi = -8; xi < 8; xi++)
      for (int yi = -8; yi < 8; yi++) begin
        int p;
        p = xi * yi;
        run(1'((xi + yi) & 1), W'(xi), W'(yi), p[2*W-1:0], "sweep");
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end
endmodule
